alu_multicycle: RTL

- Parametrised next-generation datapath ALU for the multicycle MIPS core. It replaces the purely combinational ALU.
- Keeps the same operand-source selection: A from register or PC; B from register, constant increment, sign-extend, or sign-extend<<2.
- Registers the result and adds shifts, set-less-than and overflow.
- Adds an iterative multiply/divide engine with HI/LO registers and a start/busy/done handshake. The control FSM holds the state while busy.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_multicycle_if.sv | 28 ++
 rtl/alu_muldiv.sv | 119 +++++++++++
 rtl/alu_multicycle.sv | 93 +++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, operand-source selects and mul/div FSM state for the multicycle ALU
package alu_pkg;

    localparam int ALU_CTRL_W = 5;

    localparam logic [ALU_CTRL_W-1:0]
        ALU_AND   = 5'b00000,
        ALU_OR    = 5'b00001,
        ALU_ADD   = 5'b00010,
        ALU_SUB   = 5'b00110,
        ALU_SLT   = 5'b00111,
        ALU_SLL   = 5'b01001,
        ALU_SRL   = 5'b01010,
        ALU_SRA   = 5'b01011,
        ALU_NOR   = 5'b01100,
        ALU_XOR   = 5'b01101,
        ALU_SLTU  = 5'b01110,
        ALU_MFHI  = 5'b10000,
        ALU_MFLO  = 5'b10001,
        ALU_MULTU = 5'b10100,
        ALU_MULT  = 5'b10101,
        ALU_DIVU  = 5'b10110,
        ALU_DIV   = 5'b10111;

    localparam logic SRC_A_PC  = 1'b0;
    localparam logic SRC_A_REG = 1'b1;

    localparam logic [1:0]
        SRC_B_REG     = 2'b00,
        SRC_B_INC     = 2'b01,
        SRC_B_IMM     = 2'b10,
        SRC_B_IMM_SH2 = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, FIN} md_state_t;

    function automatic logic is_muldiv(input logic [ALU_CTRL_W-1:0] ctrl);
        return ctrl inside {ALU_MULTU, ALU_MULT, ALU_DIVU, ALU_DIV};
    endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - operand, control and result bundle between the core control and the ALU
interface alu_multicycle_if #(parameter int WIDTH = 32) ();
    import alu_pkg::*;

    logic [WIDTH-1:0]      inputA;
    logic [WIDTH-1:0]      inputB;
    logic [WIDTH-1:0]      signextend;
    logic [WIDTH-1:0]      pc;
    logic                  alu_src_A;
    logic [1:0]            alu_src_B;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  start;
    logic [WIDTH-1:0]      alu_result;
    logic                  zero;
    logic                  overflow;
    logic                  busy;
    logic                  done;

    modport master (
        output inputA, inputB, signextend, pc, alu_src_A, alu_src_B, alu_control, start,
        input  alu_result, zero, overflow, busy, done
    );

    modport slave (
        input  inputA, inputB, signextend, pc, alu_src_A, alu_src_B, alu_control, start,
        output alu_result, zero, overflow, busy, done
    );
endinterface

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - iterative shift-add multiplier / restoring divider owning HI and LO
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    md_state_t state, state_next;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] acc_hi, acc_lo, operand, dividend, mag_a, mag_b;
    logic is_div, neg_q, neg_r, div_zero, a_neg, b_neg;
    logic load, step, finish;
    logic [WIDTH:0] add_sum, rem_shift, rem_diff;
    logic [2*WIDTH-1:0] product;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (start) begin
                load       = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                step = 1'b1;
                if (count == '0) state_next = FIN;
            end
            FIN: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // op[0] selects signed, op[1] selects divide; the core works on magnitudes
    always_comb begin
        a_neg     = op[0] & op_a[WIDTH-1];
        b_neg     = op[0] & op_b[WIDTH-1];
        mag_a     = a_neg ? -op_a : op_a;
        mag_b     = b_neg ? -op_b : op_b;
        add_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        rem_shift = {acc_hi, acc_lo[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, operand};
        product   = {acc_hi, acc_lo};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            operand  <= '0;
            dividend <= '0;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                acc_hi   <= '0;
                acc_lo   <= mag_a;
                operand  <= mag_b;
                dividend <= op_a;
                count    <= CW'(WIDTH - 1);
                is_div   <= op[1];
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (op_b == '0);
            end else if (step) begin
                count <= count - CW'(1);
                if (is_div) begin
                    // borrow out of the trial subtract means the divisor did not fit
                    acc_hi <= rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], ~rem_diff[WIDTH]};
                end else begin
                    acc_hi <= add_sum[WIDTH:1];
                    acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
                end
            end
            if (finish) begin
                if (!is_div) begin
                    {hi, lo} <= neg_q ? -product : product;
                end else if (div_zero) begin
                    hi <= dividend;
                    lo <= '1;
                end else begin
                    hi <= neg_r ? -acc_hi : acc_hi;
                    lo <= neg_q ? -acc_lo : acc_lo;
                end
            end
        end
    end
endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - registered datapath ALU with operand muxing and an attached mul/div engine
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PC_INC  = 1,
    parameter int SHAMT_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    alu_multicycle_if.slave bus
);
    logic [WIDTH-1:0]   in1, in2, sum, diff, result_next, result_q, hi, lo;
    logic [SHAMT_W-1:0] shamt;
    logic               overflow_next, overflow_q, zero_q;

    always_comb begin
        in1 = bus.inputA;
        case (bus.alu_src_A)
            SRC_A_PC:  in1 = bus.pc;
            SRC_A_REG: in1 = bus.inputA;
            default:   in1 = bus.inputA;
        endcase
        case (bus.alu_src_B)
            SRC_B_REG:     in2 = bus.inputB;
            SRC_B_INC:     in2 = WIDTH'(PC_INC);
            SRC_B_IMM:     in2 = bus.signextend;
            SRC_B_IMM_SH2: in2 = bus.signextend << 2;
            default:       in2 = bus.inputB;
        endcase
        sum   = in1 + in2;
        diff  = in1 - in2;
        shamt = in1[SHAMT_W-1:0];
    end

    always_comb begin
        result_next   = '0;
        overflow_next = 1'b0;
        case (bus.alu_control)
            ALU_ADD: begin
                result_next   = sum;
                overflow_next = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            ALU_SUB: begin
                result_next   = diff;
                overflow_next = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            ALU_AND:  result_next = in1 & in2;
            ALU_OR:   result_next = in1 | in2;
            ALU_NOR:  result_next = ~(in1 | in2);
            ALU_XOR:  result_next = in1 ^ in2;
            ALU_SLL:  result_next = in2 << shamt;
            ALU_SRL:  result_next = in2 >> shamt;
            ALU_SRA:  result_next = $unsigned($signed(in2) >>> shamt);
            ALU_SLT:  result_next = {{(WIDTH-1){1'b0}}, $signed(in1) < $signed(in2)};
            ALU_SLTU: result_next = {{(WIDTH-1){1'b0}}, in1 < in2};
            ALU_MFHI: result_next = hi;
            ALU_MFLO: result_next = lo;
            // mul/div results land in HI/LO; the visible result is left alone
            ALU_MULTU, ALU_MULT, ALU_DIVU, ALU_DIV: result_next = result_q;
            default:  result_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q   <= '0;
            zero_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_next;
            zero_q     <= (result_next == '0);
            overflow_q <= overflow_next;
        end
    end

    assign bus.alu_result = result_q;
    assign bus.zero       = zero_q;
    assign bus.overflow   = overflow_q;

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (bus.start & is_muldiv(bus.alu_control)),
        .op    (bus.alu_control[1:0]),
        .op_a  (in1),
        .op_b  (in2),
        .busy  (bus.busy),
        .done  (bus.done),
        .hi    (hi),
        .lo    (lo)
    );
endmodule
